// File: rtl/mine_placer.sv
// Wishbone master: clears the board, then places LFSR-chosen mines, reading each candidate back first.
// One bus transaction outstanding at a time; each master waits indefinitely for its ack.
module mine_placer #(
    parameter int          BOARD_SIZE        = 16,
    parameter int          ADDR_W            = $clog2(BOARD_SIZE * BOARD_SIZE),
    parameter int          DATA_W            = 8,
    parameter logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] mine_count,
    input  logic [ADDR_W-1:0] safe_addr,
    input  logic [15:0]       seed,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] placed,
    output logic              wr_cyc_o,
    output logic              wr_stb_o,
    output logic              wr_we_o,
    output logic [ADDR_W-1:0] wr_adr_o,
    output logic [DATA_W-1:0] wr_dat_o,
    input  logic              wr_ack_i,
    output logic              rd_cyc_o,
    output logic              rd_stb_o,
    output logic [ADDR_W-1:0] rd_adr_o,
    input  logic [DATA_W-1:0] rd_dat_i,
    input  logic              rd_ack_i
);
    localparam int                N      = BOARD_SIZE * BOARD_SIZE;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(N - 1);
    localparam logic [ADDR_W:0]   N_W    = (ADDR_W + 1)'(N);
    localparam logic [DATA_W-1:0] MINE_W = {{(DATA_W - 1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_GEN, S_CHECK, S_PLACE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d, lfsr_next;
    logic [ADDR_W-1:0] target_q, target_d, safe_q, safe_d, placed_q, placed_d;
    logic [ADDR_W-1:0] wr_adr_q, wr_adr_d, rd_adr_q, rd_adr_d, cand;
    logic [DATA_W-1:0] wr_dat_q, wr_dat_d;
    logic              wr_cyc_q, wr_cyc_d, rd_cyc_q, rd_cyc_d;
    logic              busy_q, busy_d, done_q, done_d;

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        target_d  = target_q;
        safe_d    = safe_q;
        placed_d  = placed_q;
        wr_adr_d  = wr_adr_q;
        wr_dat_d  = wr_dat_q;
        wr_cyc_d  = wr_cyc_q;
        rd_adr_d  = rd_adr_q;
        rd_cyc_d  = rd_cyc_q;
        busy_d    = busy_q;
        done_d    = done_q;
        lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
        cand      = lfsr_q[ADDR_W-1:0];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    target_d = (mine_count > LAST) ? LAST : mine_count;
                    safe_d   = safe_addr;
                    lfsr_d   = (seed == 16'h0) ? LFSR_DEFAULT_SEED : seed;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    placed_d = '0;
                    wr_cyc_d = 1'b1;
                    wr_adr_d = '0;
                    wr_dat_d = '0;
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // Bus idles one cycle after each ack before the next address goes out.
                if (wr_cyc_q) begin
                    if (wr_ack_i) begin
                        wr_cyc_d = 1'b0;
                        if (wr_adr_q == LAST) begin
                            if (target_q == '0) begin
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                state_d = S_GEN;
                            end
                        end
                    end
                end else begin
                    wr_cyc_d = 1'b1;
                    wr_adr_d = wr_adr_q + 1'b1;
                end
            end
            S_GEN: begin
                lfsr_d = lfsr_next;
                if (({1'b0, cand} < N_W) && (cand != safe_q)) begin
                    rd_cyc_d = 1'b1;
                    rd_adr_d = cand;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (rd_ack_i) begin
                    rd_cyc_d = 1'b0;
                    if (rd_dat_i[0]) begin
                        state_d = S_GEN;
                    end else begin
                        wr_cyc_d = 1'b1;
                        wr_adr_d = rd_adr_q;
                        wr_dat_d = MINE_W;
                        state_d  = S_PLACE;
                    end
                end
            end
            S_PLACE: begin
                if (wr_ack_i) begin
                    wr_cyc_d = 1'b0;
                    placed_d = placed_q + 1'b1;
                    if (placed_d == target_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GEN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lfsr_q   <= LFSR_DEFAULT_SEED;
            target_q <= '0;
            safe_q   <= '0;
            placed_q <= '0;
            wr_adr_q <= '0;
            wr_dat_q <= '0;
            wr_cyc_q <= 1'b0;
            rd_adr_q <= '0;
            rd_cyc_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            target_q <= target_d;
            safe_q   <= safe_d;
            placed_q <= placed_d;
            wr_adr_q <= wr_adr_d;
            wr_dat_q <= wr_dat_d;
            wr_cyc_q <= wr_cyc_d;
            rd_adr_q <= rd_adr_d;
            rd_cyc_q <= rd_cyc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign placed   = placed_q;
    assign wr_cyc_o = wr_cyc_q;
    assign wr_stb_o = wr_cyc_q;
    assign wr_we_o  = wr_cyc_q;
    assign wr_adr_o = wr_adr_q;
    assign wr_dat_o = wr_dat_q;
    assign rd_cyc_o = rd_cyc_q;
    assign rd_stb_o = rd_cyc_q;
    assign rd_adr_o = rd_adr_q;
endmodule
